lms_spi_master_param: RTL
=========================

LMS_SPI_MASTER_PARAM -- requirements
Module: lms_spi_master_param

Interface
REQ-001 SHALL have parameter DATA_W, 8, bits per SPI word (8..32).
REQ-002 SHALL have parameter NUM_SS, 2, number of slave-select lines (1..16).
REQ-003 SHALL have parameter CLK_DIV, 3, clk cycles per SCLK half-period (>=1).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports mode_cpol, mode_cpha, mode_lsb_first  input  1 each  runtime SPI mode, sampled only in IDLE.
REQ-007 SHALL have ports tx_valid  input  1, tx_ready  output  1, tx_data  input  DATA_W, tx_ss  input  NUM_SS (one-hot target), tx_last  input  1 (release SS after this word).
REQ-008 SHALL have ports rx_valid  output  1, rx_ready  input  1, rx_data  output  DATA_W.
REQ-009 SHALL have ports busy  output  1, rx_overrun  output  1 (sticky), status_clr  input  1.
REQ-010 SHALL have ports SCLK  output  1, MOSI  output  1, MISO  input  1, SS_n  output  NUM_SS.

Function
REQ-011 SHALL accept a word when tx_valid & tx_ready on a rising clk edge.
REQ-012 SHALL implement states IDLE, LEAD, XFER, TRAIL; IDLE->LEAD on accepted word with SS idle; LEAD->XFER after CLK_DIV cycles; XFER->TRAIL after 2*DATA_W half-periods; TRAIL->IDLE after CLK_DIV cycles when tx_last=1 or no pending word.
REQ-013 SHALL, in TRAIL with tx_last=0 and a pending word for the same tx_ss, go directly to XFER keeping SS_n asserted (no deassert gap).
REQ-014 SHALL, with a pending word for a different tx_ss, deassert SS_n for one full TRAIL before LEAD.
REQ-015 SHALL hold SCLK at mode_cpol in IDLE, LEAD, TRAIL; toggle every CLK_DIV cycles in XFER.
REQ-016 SHALL sample MISO on the leading SCLK edge when cpha=0, trailing edge when cpha=1; MOSI changes on the opposite edge; with cpha=0 first bit valid at LEAD entry.
REQ-017 SHALL shift MSB first when mode_lsb_first=0, LSB first when 1.
REQ-018 SHALL drive SS_n[i]=0 only for tx_ss[i]=1 during LEAD/XFER/TRAIL; all ones otherwise.
REQ-019 SHALL assert rx_valid the cycle after TRAIL entry with received word; hold rx_valid and rx_data until rx_valid & rx_ready.
REQ-020 SHALL, if a new word completes while rx_valid=1 and rx_ready=0, overwrite rx_data and set rx_overrun; rx_overrun clears on status_clr; set wins if simultaneous.
REQ-021 SHALL assert busy whenever state != IDLE or a word is pending.
REQ-022 SHALL ignore mode input changes outside IDLE.

Reset
REQ-023 SHALL, on reset_n=0 at clk edge, enter IDLE, discard pending words, set SCLK=0, MOSI=0, SS_n=all ones, tx_ready=0, rx_valid=0, rx_data=0, rx_overrun=0, busy=0; tx_ready rises the cycle after reset release.
REQ-024 SHALL abort any in-progress transfer on reset without emitting rx_valid.

Configuration
REQ-025 SHALL, with macro LMS_SPI_MASTER_TXFIFO_EN defined, buffer up to 4 words (tx_data, tx_ss, tx_last); tx_ready=0 only when full.
REQ-026 SHALL, without LMS_SPI_MASTER_TXFIFO_EN, use a single holding register; tx_ready=0 while holding register occupied.

Verification
REQ-027 SHALL cover: DATA_W=8, CLK_DIV=3, cpol=0 cpha=1, tx 0xA5 to ss=01, MISO loopback -> SCLK period 6 clks, 8 pulses, rx_data=0xA5, SS_n=2'b10 during transfer.
REQ-028 SHALL cover: all four cpol/cpha combinations with lsb_first=1, tx 0x3C -> MOSI bit order 0,0,1,1,1,1,0,0 on correct edges.
REQ-029 SHALL cover: two words tx_last=0 then 1, same ss -> SS_n stays low continuously for 16 SCLK pulses, then releases.
REQ-030 SHALL cover: rx_ready=0, send 2 words -> second rx_data present, rx_overrun=1; status_clr -> rx_overrun=0.
REQ-031 SHALL cover: reset_n=0 mid-XFER -> next cycle SS_n=all ones, SCLK=0, rx_valid never asserted.
REQ-032 SHALL cover: with FIFO enabled, 5 back-to-back tx_valid -> tx_ready drops after 4 accepts, all 5 words transmitted in order.

Source files
------------

// File: rtl/lms_spi_master_param.sv
// SPI master with runtime CPOL/CPHA/bit order, one-hot slave select and a TX holding stage.
// Define LMS_SPI_MASTER_TXFIFO_EN to replace the single holding register with a 4-deep TX FIFO.
module lms_spi_master_param #(
   parameter int DATA_W  = 8,
   parameter int NUM_SS  = 2,
   parameter int CLK_DIV = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mode_cpol,
   input  logic              mode_cpha,
   input  logic              mode_lsb_first,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [NUM_SS-1:0] tx_ss,
   input  logic              tx_last,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              rx_overrun,
   input  logic              status_clr,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO,
   output logic [NUM_SS-1:0] SS_n
);
   localparam int EW = $clog2(2 * DATA_W);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [EW-1:0] LAST_E = EW'(2 * DATA_W - 1);
   localparam logic [CW-1:0] LAST_D = CW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

   state_t r_state, w_nstate;
   logic              w_pop, w_gap_set, w_push, w_full, w_pend, w_plast;
   logic [DATA_W-1:0] w_pdata;
   logic [NUM_SS-1:0] w_pss;
   logic              r_rdy_en, r_gap, r_last, r_done, r_sclk;
   logic              r_cpol, r_cpha, r_lsb, r_rxv, r_ovr;
   logic [CW-1:0]     r_div;
   logic [EW-1:0]     r_edge;
   logic [DATA_W-1:0] r_tx, r_rx, r_rxd;
   logic [NUM_SS-1:0] r_ss;
   logic              w_tick, w_lead, w_samp, w_shift;

   assign w_push = tx_valid & tx_ready;

`ifdef LMS_SPI_MASTER_TXFIFO_EN
   logic [DATA_W-1:0] r_fd [4];
   logic [NUM_SS-1:0] r_fs [4];
   logic              r_fl [4];
   logic [1:0]        r_wp, r_rp;
   logic [2:0]        r_cnt;

   // Four-entry circular buffer of pending words
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_fd[r_wp] <= tx_data;
            r_fs[r_wp] <= tx_ss;
            r_fl[r_wp] <= tx_last;
            r_wp       <= r_wp + 2'd1;
         end
         if (w_pop) r_rp <= r_rp + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 3'd1;
            2'b01:   r_cnt <= r_cnt - 3'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign w_pend  = (r_cnt != 3'd0);
   assign w_full  = (r_cnt == 3'd4);
   assign w_pdata = r_fd[r_rp];
   assign w_pss   = r_fs[r_rp];
   assign w_plast = r_fl[r_rp];
`else
   logic              r_hv, r_hl;
   logic [DATA_W-1:0] r_hd;
   logic [NUM_SS-1:0] r_hs;

   // Single holding register for the next word
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hv <= 1'b0;
         r_hl <= 1'b0;
         r_hd <= '0;
         r_hs <= '0;
      end else if (w_push) begin
         r_hv <= 1'b1;
         r_hl <= tx_last;
         r_hd <= tx_data;
         r_hs <= tx_ss;
      end else if (w_pop) begin
         r_hv <= 1'b0;
      end
   end

   assign w_pend  = r_hv;
   assign w_full  = r_hv;
   assign w_pdata = r_hd;
   assign w_pss   = r_hs;
   assign w_plast = r_hl;
`endif

   assign w_tick  = (r_div == LAST_D);
   assign w_lead  = ~r_edge[0];
   assign w_samp  = r_cpha ? ~w_lead : w_lead;
   assign w_shift = r_cpha ? (w_lead && r_edge != '0) : ~w_lead;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_nstate;
   end

   // Next-state decode; a new target SS forces one SS-high TRAIL first
   always_comb begin
      w_nstate  = r_state;
      w_pop     = 1'b0;
      w_gap_set = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_pend) begin
               w_nstate = LEAD;
               w_pop    = 1'b1;
            end
         end
         LEAD: if (w_tick) w_nstate = XFER;
         XFER: if (w_tick && r_edge == LAST_E) w_nstate = TRAIL;
         TRAIL: begin
            if (w_tick) begin
               if (r_gap) begin
                  w_nstate = LEAD;
                  w_pop    = 1'b1;
               end else if (!r_last && w_pend && w_pss == r_ss) begin
                  w_nstate = XFER;
                  w_pop    = 1'b1;
               end else if (!r_last && w_pend) begin
                  w_gap_set = 1'b1;
               end else begin
                  w_nstate = IDLE;
               end
            end
         end
         default: w_nstate = IDLE;
      endcase
   end

   // Timing counters, shifters, SCLK and receive status
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rdy_en <= 1'b0;
         r_div    <= '0;
         r_edge   <= '0;
         r_gap    <= 1'b0;
         r_sclk   <= 1'b0;
         r_tx     <= '0;
         r_rx     <= '0;
         r_ss     <= '0;
         r_last   <= 1'b0;
         r_cpol   <= 1'b0;
         r_cpha   <= 1'b0;
         r_lsb    <= 1'b0;
         r_done   <= 1'b0;
         r_rxv    <= 1'b0;
         r_rxd    <= '0;
         r_ovr    <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (r_state == IDLE || w_tick) r_div <= '0;
         else                           r_div <= r_div + 1'b1;
         if (r_state != XFER) r_edge <= '0;
         else if (w_tick)     r_edge <= r_edge + 1'b1;
         if (w_gap_set)              r_gap <= 1'b1;
         else if (w_nstate != TRAIL) r_gap <= 1'b0;
         if (r_state == IDLE)              r_sclk <= mode_cpol;
         else if (r_state == XFER && w_tick) r_sclk <= ~r_sclk;
         if (w_pop) begin
            r_tx   <= w_pdata;
            r_ss   <= w_pss;
            r_last <= w_plast;
            if (r_state == IDLE) begin
               r_cpol <= mode_cpol;
               r_cpha <= mode_cpha;
               r_lsb  <= mode_lsb_first;
            end
         end else if (r_state == XFER && w_tick) begin
            if (w_shift) r_tx <= r_lsb ? (r_tx >> 1) : (r_tx << 1);
            if (w_samp)
               r_rx <= r_lsb ? {MISO, r_rx[DATA_W-1:1]}
                             : {r_rx[DATA_W-2:0], MISO};
         end
         r_done <= (r_state == XFER) && (w_nstate == TRAIL);
         if (r_done) begin
            r_rxd <= r_rx;
            r_rxv <= 1'b1;
         end else if (r_rxv && rx_ready) begin
            r_rxv <= 1'b0;
         end
         if (r_done && r_rxv && !rx_ready) r_ovr <= 1'b1;
         else if (status_clr)              r_ovr <= 1'b0;
      end
   end

   assign tx_ready   = r_rdy_en & ~w_full;
   assign busy       = (r_state != IDLE) | w_pend;
   assign rx_valid   = r_rxv;
   assign rx_data    = r_rxd;
   assign rx_overrun = r_ovr;
   assign SCLK       = r_sclk;
   assign MOSI       = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
   assign SS_n       = (r_state != IDLE && !r_gap) ? ~r_ss : '1;
endmodule
